// File: rtl/frame_pkg.sv
// Shared framing definitions for the frame/word transmit generator and the receiver.
package frame_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned BC_W           = 4;
    localparam int unsigned MISS_W         = 4;
    localparam int unsigned DEF_MISS_LIMIT = 2;

    localparam logic [WORD_W-1:0] DEF_SYNC1 = 16'hEB90;
    localparam logic [WORD_W-1:0] DEF_SYNC2 = 16'h146F;

    typedef enum logic [2:0] {
        SEARCH,
        CHK2,
        DATA,
        VFY1,
        VFY2
    } state_t;

    // A frame always carries at least one data word.
    function automatic logic [WORD_W-1:0] eff_nw(input logic [WORD_W-1:0] n);
        return (n == '0) ? WORD_W'(1) : n;
    endfunction

endpackage

// File: rtl/word_deserializer.sv
// Serial-to-parallel shifter with a word-boundary bit counter that can be re-aligned.
module word_deserializer
    import frame_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bit,
    input  logic              i_align,
    output logic [WORD_W-1:0] o_sr_next_c,
    output logic              o_word_done_c
);

    logic [WORD_W-1:0] r_sr;
    logic [BC_W-1:0]   r_bc;

    // Post-shift view so a word is usable on the edge that samples its last bit.
    assign o_sr_next_c   = {r_sr[WORD_W-2:0], i_bit};
    assign o_word_done_c = (r_bc == BC_W'(WORD_W - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr <= '0;
            r_bc <= '0;
        end else begin
            r_sr <= o_sr_next_c;
            r_bc <= i_align ? '0 : r_bc + BC_W'(1);
        end
    end

endmodule

// File: rtl/frame_sync_receiver.sv
// Frame sync receiver: hunts SYNC1/SYNC2, deserializes data words, flywheels over sync errors.
// Optional build macro SYNC_INVERT_EN also locks onto a bit-inverted stream.
module frame_sync_receiver
    import frame_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC1      = DEF_SYNC1,
    parameter logic [WORD_W-1:0] SYNC2      = DEF_SYNC2,
    parameter int unsigned       MISS_LIMIT = DEF_MISS_LIMIT
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              bit_in,
    input  logic [WORD_W-1:0] num_word,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              locked,
    output logic              sync_err
);

    state_t              r_state, w_state_nxt;
    logic [WORD_W-1:0]   r_wc, w_wc_nxt;
    logic [WORD_W-1:0]   r_nw, w_nw_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [MISS_W:0]     w_miss_inc;
    logic                r_vfy1_ok, w_vfy1_ok_nxt;
    logic [WORD_W-1:0]   w_sr, w_data_nxt, w_pol, w_exp1, w_exp2;
    logic                w_word_done, w_align, w_last;
    logic                w_valid_nxt, w_fs_nxt, w_fe_nxt, w_err_nxt, w_locked_nxt;

`ifdef SYNC_INVERT_EN
    logic r_inv, w_inv_nxt;
    assign w_pol = {WORD_W{r_inv}};
`else
    assign w_pol = '0;
`endif

    word_deserializer u_deser (
        .i_clk         (clock_in),
        .i_rst_n       (reset_n),
        .i_bit         (bit_in),
        .i_align       (w_align),
        .o_sr_next_c   (w_sr),
        .o_word_done_c (w_word_done)
    );

    assign w_exp1     = SYNC1 ^ w_pol;
    assign w_exp2     = SYNC2 ^ w_pol;
    assign w_last     = (r_wc == r_nw - WORD_W'(1));
    assign w_miss_inc = {1'b0, r_miss} + (MISS_W + 1)'(1);

    always_ff @(posedge clock_in) begin
        if (!reset_n) r_state <= SEARCH;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_align       = 1'b0;
        w_wc_nxt      = r_wc;
        w_nw_nxt      = r_nw;
        w_miss_nxt    = r_miss;
        w_vfy1_ok_nxt = r_vfy1_ok;
        w_data_nxt    = word_data;
        w_valid_nxt   = 1'b0;
        w_fs_nxt      = 1'b0;
        w_fe_nxt      = 1'b0;
        w_err_nxt     = 1'b0;
`ifdef SYNC_INVERT_EN
        w_inv_nxt     = r_inv;
`endif
        case (r_state)
            SEARCH: begin
                if (w_sr == SYNC1) begin
                    w_align     = 1'b1;
                    w_state_nxt = CHK2;
                end
`ifdef SYNC_INVERT_EN
                else if (w_sr == ~SYNC1) begin
                    w_align     = 1'b1;
                    w_inv_nxt   = 1'b1;
                    w_state_nxt = CHK2;
                end
`endif
            end
            CHK2: begin
                if (w_word_done) begin
                    if (w_sr == w_exp2) begin
                        w_nw_nxt    = eff_nw(num_word);
                        w_wc_nxt    = '0;
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = SEARCH;
                    end
                end
            end
            DATA: begin
                if (w_word_done) begin
                    w_data_nxt  = w_sr ^ w_pol;
                    w_valid_nxt = 1'b1;
                    w_fs_nxt    = (r_wc == '0);
                    w_fe_nxt    = w_last;
                    if (w_last) begin
                        w_wc_nxt    = '0;
                        w_state_nxt = VFY1;
                    end else begin
                        w_wc_nxt = r_wc + WORD_W'(1);
                    end
                end
            end
            VFY1: begin
                if (w_word_done) begin
                    w_vfy1_ok_nxt = (w_sr == w_exp1);
                    w_state_nxt   = VFY2;
                end
            end
            VFY2: begin
                // A bad pair below the miss limit still re-enters DATA (flywheel).
                if (w_word_done) begin
                    w_nw_nxt    = eff_nw(num_word);
                    w_wc_nxt    = '0;
                    w_state_nxt = DATA;
                    if (r_vfy1_ok && (w_sr == w_exp2)) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (w_miss_inc >= (MISS_W + 1)'(MISS_LIMIT)) begin
                            w_miss_nxt  = '0;
                            w_state_nxt = SEARCH;
                        end else begin
                            w_miss_nxt = MISS_W'(w_miss_inc);
                        end
                    end
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
        w_locked_nxt = (w_state_nxt == DATA) || (w_state_nxt == VFY1) || (w_state_nxt == VFY2);
`ifdef SYNC_INVERT_EN
        if (w_state_nxt == SEARCH) w_inv_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_wc        <= '0;
            r_nw        <= WORD_W'(1);
            r_miss      <= '0;
            r_vfy1_ok   <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef SYNC_INVERT_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_wc        <= w_wc_nxt;
            r_nw        <= w_nw_nxt;
            r_miss      <= w_miss_nxt;
            r_vfy1_ok   <= w_vfy1_ok_nxt;
            word_data   <= w_data_nxt;
            word_valid  <= w_valid_nxt;
            frame_start <= w_fs_nxt;
            frame_end   <= w_fe_nxt;
            locked      <= w_locked_nxt;
            sync_err    <= w_err_nxt;
`ifdef SYNC_INVERT_EN
            r_inv       <= w_inv_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_frame_sync_receiver.sv
// Bench for frame_sync_receiver: frame-level reference model, vector table and random frames.
`timescale 1ns/1ps
module tb_frame_sync_receiver;

    localparam logic [15:0] S1       = 16'hEB90;
    localparam logic [15:0] S2       = 16'h146F;
    localparam int          MISS_LIM = 2;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        bit_in   = 1'b0;
    logic [15:0] num_word = 16'd0;
    logic [15:0] word_data;
    logic        word_valid, frame_start, frame_end, locked, sync_err;

    frame_sync_receiver dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .bit_in      (bit_in),
        .num_word    (num_word),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    // Frame-level model of what the receiver should report.
    bit          m_locked = 1'b0;
    int          m_miss   = 0;
    int          m_nw     = 1;
    bit          m_inv    = 1'b0;
    logic [15:0] m_data   = 16'h0;

    // Events that land on the last bit of the next word sent.
    bit          p_valid = 0, p_fs = 0, p_fe = 0, p_err = 0, p_lock_set = 0, p_lock_val = 0;
    logic [15:0] p_data  = 16'h0;
    logic        last_err, last_locked;

    typedef struct {
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] nw;
        logic        exp_err;
        logic        exp_lk;
        int          exp_n;
    } vec_t;

    function automatic int eff(input logic [15:0] n);
        return (n == 16'd0) ? 1 : int'(n);
    endfunction

    function automatic logic [15:0] txw(input logic [15:0] w);
        return m_inv ? ~w : w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input bit ev_valid, input bit ev_fs, input bit ev_fe,
                        input bit ev_err, input logic [15:0] ev_data);
        logic [20:0] exp_v, act_v;
        bit_in = b;
        @(posedge clock_in);
        #1;
        if (ev_valid) m_data = ev_data;
        exp_v = {ev_valid, ev_fs, ev_fe, ev_err, m_locked, m_data};
        act_v = {word_valid, frame_start, frame_end, sync_err, locked, word_data};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            if (failures <= 25)
                $display("FAIL outputs t=%0t actual v/fs/fe/err/lk=%b%b%b%b%b data=%h required=%b%b%b%b%b data=%h",
                         $time, act_v[20], act_v[19], act_v[18], act_v[17], act_v[16], act_v[15:0],
                         exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
        end
        if (word_valid === 1'b1) strobes++;
        last_err    = sync_err;
        last_locked = locked;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) begin
                if (p_lock_set) m_locked = p_lock_val;
                step(w[i], p_valid, p_fs, p_fe, p_err, p_data);
                p_valid = 0; p_fs = 0; p_fe = 0; p_err = 0; p_lock_set = 0;
            end else begin
                step(w[i], 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            end
        end
    endtask

    task automatic fill(input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Random bits that cannot be mistaken for a sync word, including overlaps into the next SYNC1.
    task automatic preamble(input int n);
        logic [15:0] win;
        logic [15:0] s1v;
        bit          ok;
        logic        q[$];
        s1v = S1;
        do begin
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(1'($urandom));
            win = 16'h0;
            ok  = 1'b1;
            foreach (q[i]) begin
                win = {win[14:0], q[i]};
                if (win == S1 || win == ~S1) ok = 1'b0;
            end
            for (int j = 0; j < 15; j++) begin
                win = {win[14:0], s1v[15-j]};
                if (win == S1 || win == ~S1) ok = 1'b0;
            end
        end while (!ok);
        foreach (q[i]) step(q[i], 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic relock(input logic [15:0] nw, input bit inv);
        m_inv    = inv;
        num_word = nw;
        send_word(txw(S1));
        p_lock_set = 1; p_lock_val = 1;
        send_word(txw(S2));
        m_miss = 0;
        m_nw   = eff(nw);
    endtask

    task automatic send_data_frame(input bit chg, input logic [15:0] chg_val,
                                   input bit use_rand, input logic [15:0] base);
        int          n;
        logic [15:0] w;
        n = m_nw;
        for (int k = 0; k < n; k++) begin
            if (use_rand) w = ($urandom_range(0, 9) == 0) ? S1 : 16'($urandom);
            else          w = base + 16'(k);
            if (chg && k == 1) num_word = chg_val;
            p_valid = 1; p_data = w; p_fs = (k == 0); p_fe = (k == n - 1);
            send_word(txw(w));
        end
    endtask

    task automatic send_vfy(input logic [15:0] s1, input logic [15:0] s2);
        bit good;
        good = (s1 == S1) && (s2 == S2);
        send_word(txw(s1));
        if (good) begin
            m_miss = 0;
            m_nw   = eff(num_word);
        end else begin
            p_err = 1;
            m_miss++;
            if (m_miss >= MISS_LIM) begin
                p_lock_set = 1; p_lock_val = 0; m_miss = 0;
            end else begin
                m_nw = eff(num_word);
            end
        end
        send_word(txw(s2));
        if (!m_locked) m_inv = 0;
    endtask

    initial begin
        vec_t        tbl[7];
        int          s0;
        int          r;
        logic [15:0] s1r, s2r, one;

        tbl[0] = '{S1,        S2,        16'd3, 1'b0, 1'b1, 3};
        tbl[1] = '{16'hEB91,  S2,        16'd3, 1'b1, 1'b1, 3};
        tbl[2] = '{S1,        S2,        16'd1, 1'b0, 1'b1, 1};
        tbl[3] = '{S1,        16'h046F,  16'd0, 1'b1, 1'b1, 1};
        tbl[4] = '{S1,        S2,        16'd2, 1'b0, 1'b1, 2};
        tbl[5] = '{S1,        16'h146E,  16'd2, 1'b1, 1'b1, 2};
        tbl[6] = '{16'h0000,  16'h0000,  16'd2, 1'b1, 1'b0, 0};
        one = 16'h1;

        // Reset state
        reset_n = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b1;

        // Preamble, lock, three frames of 0001..0004
        preamble(37);
        relock(16'd4, 1'b0);
        chk("t1_locked_after_sync2", int'(last_locked), 1);
        s0 = strobes;
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);
        chk("t1_strobes", strobes - s0, 12);

        // Single corrupted SYNC1 is ridden out; miss count clears on the next good pair
        num_word = 16'd3;
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h10);
        send_vfy(16'hEB91, S2);
        chk("t2_err", int'(last_err), 1);
        chk("t2_lock_held", int'(last_locked), 1);
        s0 = strobes;
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h20);
        chk("t2_flywheel_strobes", strobes - s0, 3);
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h30);
        send_vfy(S1, 16'h0000);
        chk("t2_miss_cleared", int'(last_locked), 1);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h40);
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h50);

        // Vector table of sync pairs and frame lengths
        for (int v = 0; v < 7; v++) begin
            num_word = tbl[v].nw;
            send_vfy(tbl[v].s1, tbl[v].s2);
            chk($sformatf("tbl%0d_err", v), int'(last_err), int'(tbl[v].exp_err));
            chk($sformatf("tbl%0d_locked", v), int'(last_locked), int'(tbl[v].exp_lk));
            s0 = strobes;
            if (m_locked) send_data_frame(1'b0, 16'h0, 1'b0, 16'(16'h100 * v));
            chk($sformatf("tbl%0d_strobes", v), strobes - s0, tbl[v].exp_n);
        end

        // Two consecutive bad pairs drop lock; silence until a fresh relock
        fill(32);
        relock(16'd2, 1'b0);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h60);
        send_vfy(S1 ^ 16'h0001, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h70);
        send_vfy(S1, S2 ^ 16'h0100);
        chk("t3_err2", int'(last_err), 1);
        chk("t3_dropped", int'(last_locked), 0);
        s0 = strobes;
        fill(48);
        chk("t3_no_strobes", strobes - s0, 0);

        // SYNC1 then a wrong word does not lock; valid pair five bits later does
        send_word(S1);
        send_word(16'h0000);
        chk("t4_no_lock", int'(last_locked), 0);
        fill(5);
        relock(16'd3, 1'b0);
        chk("t4_relock", int'(last_locked), 1);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h80);

        // num_word change mid-frame applies only after the next sync pair; SYNC1 as data
        num_word = 16'd2;
        send_vfy(S1, S2);
        s0 = strobes;
        send_data_frame(1'b1, 16'd5, 1'b0, 16'h90);
        chk("t5_old_len", strobes - s0, 2);
        send_vfy(S1, S2);
        s0 = strobes;
        send_data_frame(1'b0, 16'h0, 1'b0, S1);
        chk("t5_new_len", strobes - s0, 5);

        // Reset mid data word
        num_word = 16'd4;
        send_vfy(S1, S2);
        for (int i = 0; i < 7; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b0;
        m_locked = 0; m_data = 16'h0; m_miss = 0; m_inv = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b1;
        s0 = strobes;
        fill(20);
        chk("t6_no_spurious", strobes - s0, 0);
        relock(16'd4, 1'b0);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);

        // Randomized frames checked against the model
        for (int it = 0; it < 40; it++) begin
            if (!m_locked) begin
                fill(16);
                relock(16'($urandom_range(0, 5)), 1'b0);
            end else begin
                num_word = 16'($urandom_range(0, 5));
                r   = $urandom_range(0, 9);
                s1r = S1;
                s2r = S2;
                if (r == 0)      s1r = S1 ^ (one << $urandom_range(0, 15));
                else if (r == 1) s2r = S2 ^ (one << $urandom_range(0, 15));
                send_vfy(s1r, s2r);
            end
            if (m_locked) send_data_frame(1'b0, 16'h0, 1'b1, 16'h0);
        end

`ifdef SYNC_INVERT_EN
        // Inverted stream locks and yields true-polarity data
        reset_n = 1'b0;
        m_locked = 0; m_data = 16'h0; m_miss = 0; m_inv = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b1;
        fill(16);
        relock(16'd4, 1'b1);
        chk("t6_inv_lock", int'(last_locked), 1);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);
        send_vfy(S1, S2);
        send_data_frame(1'b0, 16'h0, 1'b0, 16'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
